result_uart_tx: RTL
===================

# result_uart_tx

Serial reporter that sits downstream of the FPU/ALU board top. On a single-cycle `send` pulse it captures a result word, its five status flags and the precision mode. It then transmits them over the Basys3 USB-UART as an ASCII hex line. A host terminal can log every computation without reading LEDs.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency in Hz
- `BAUD`, 115200: UART bit rate; `CLKS_PER_BIT = CLK_HZ / BAUD` (integer division, 868 at defaults); must be ≥ 2
- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  reset, asynchronous, active-high
- `send`  input  1  request pulse; sampled only while `busy` = 0
- `result`  input  32  value to report; captured on accepted `send`
- `flags`  input  5  ALU flags; captured on accepted `send`
- `mode_fp`  input  1  captured on accepted `send`; 1 = single precision (8 hex digits), 0 = half precision (4 hex digits of `result[15:0]`)
- `tx`  output  1  UART line, 8N1, LSB first, idle high
- `busy`  output  1  high from acceptance until the line is fully sent
- `done`  output  1  one-cycle pulse when the last stop bit ends

## Operation
- Reset (async, immediate): `tx` = 1, `busy` = 0, `done` = 0. FSM goes to IDLE and all counters and capture registers clear.
- Acceptance: `send` = 1 while in IDLE captures `result`, `{3'b000, flags}` and `mode_fp` into registers. Later input changes have no effect on the line.
- Line format, characters sent in order:
  - mode 1: 8 hex digits of result[31:0], MSB nibble first, then 0x20, then 2 hex digits of the flag byte, then 0x0D, 0x0A. N = 13.
  - mode 0: 4 hex digits of result[15:0], then 0x20, 2 flag digits, 0x0D, 0x0A. N = 9.
- Hex encoding, uppercase only:
  - nibble 0–9 → 0x30–0x39
  - nibble A–F → 0x41–0x46
- FSM states:
  - IDLE: `tx` = 1. On `send` go to START.
  - START: `tx` = 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, bit 0 first, each held CLKS_PER_BIT cycles, then STOP.
  - STOP: `tx` = 1 for CLKS_PER_BIT cycles. If characters remain, go to START for the next character, with no idle gap. Otherwise go to IDLE and pulse `done`.
- Character index counter: 0..N-1; the character byte is selected combinationally from the index and the captured registers.
- Bit counter: 0..7. Baud counter: 0..CLKS_PER_BIT-1, restarts at each bit boundary.
- `send` while `busy` = 1 is ignored: no queueing, no restart, no effect on the captured data.

## Timing
- `send` sampled high at edge k:
  - `busy` = 1 and `tx` = 0 (start bit) from edge k+1.
- Each character occupies exactly 10·CLKS_PER_BIT cycles. The line takes T = N·10·CLKS_PER_BIT cycles: 9·10·868 = 78 120 (HP) and 13·10·868 = 112 840 (SP) at defaults.
- At edge k+1+T:
  - `busy` = 0 and `done` = 1 for exactly one cycle.
  - A `send` sampled at that edge is accepted, so back-to-back lines are possible.
- `send` held high continuously: one line per acceptance. Each new line starts the cycle `busy` falls.
- `rst` asserted mid-character:
  - `tx` returns high asynchronously and no `done` pulse is produced.
  - After release the block is in IDLE and accepts the next `send` normally.

## Test plan
Bench parameters: CLK_HZ = 10, BAUD = 1, so CLKS_PER_BIT = 10. The UART monitor samples mid-bit.

- Reset check: assert `rst` with no clock edge → `tx` = 1, `busy` = 0, `done` = 0 immediately. Hold for 5 cycles → unchanged.
- Half-precision line: `result` = 0x00003C00, `flags` = 0, `mode_fp` = 0, pulse `send`.
  - Monitor decodes bytes 0x33 0x43 0x30 0x30 0x20 0x30 0x30 0x0D 0x0A.
  - `busy` is high for exactly 900 cycles, then `done` pulses once.
- Single-precision line: `result` = 0x3F800000, `flags` = 5'b10001, `mode_fp` = 1 → monitor decodes "3F800000 11\r\n" (13 bytes); `busy` is high for 1300 cycles.
- Hex letters: `result` = 0xABCDEF01, `flags` = 5'b11111, `mode_fp` = 1 → "ABCDEF01 1F\r\n".
- Busy protection: during the first line, pulse `send` again with `result` = 0xFFFFFFFF → the first line is unchanged and the second request is not transmitted. `send` at the `done` cycle → a new line starts on the next edge.
- Reset mid-frame: assert `rst` during the DATA bits of character 3 → `tx` = 1 at once and no `done`. Release and send 0x00001234 in HP → "1234 00\r\n" is received correctly.

Source files
------------

// File: rtl/result_uart_tx.sv
// result_uart_tx: serial reporter for FPU/ALU results.
// On an accepted send pulse it captures a 32-bit result, five flags and the
// precision mode. It then sends one ASCII hex line over an 8N1 UART:
//   mode_fp_i = 1 : 8 hex digits, ' ', 2 flag digits, CR, LF (13 chars)
//   mode_fp_i = 0 : 4 hex digits of result[15:0], ' ', 2 flag digits, CR, LF (9 chars)
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   send_i     request pulse, sampled only while idle
//   result_i   value to report
//   flags_i    ALU flags, sent as the byte {3'b000, flags}
//   mode_fp_i  1 = single precision line, 0 = half precision line
//   tx_o       UART line, idle high
//   busy_o     high from acceptance until the last stop bit ends
//   done_o     one-cycle pulse when the line is complete
module result_uart_tx #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_i,
    input  logic [31:0] result_i,
    input  logic [4:0]  flags_i,
    input  logic        mode_fp_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned ClksPerBit = CLK_HZ / BAUD;
    localparam int unsigned BaudW      = $clog2(ClksPerBit);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q;
    logic [BaudW-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [3:0]       chr_q;
    logic [31:0]      result_q;
    logic [7:0]       flag_q;
    logic             mode_q;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;

    logic [3:0] eff_idx;
    logic [3:0] last_idx;
    logic [3:0] nib;
    logic [7:0] char_byte;
    logic       baud_last;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // A half-precision line is the single-precision line with its first four
    // characters skipped: result[15:0] are nibbles 4..7 of result[31:0].
    always_comb begin
        eff_idx   = mode_q ? chr_q : (chr_q + 4'd4);
        last_idx  = mode_q ? 4'd12 : 4'd8;
        nib       = result_q[{3'd7 - eff_idx[2:0], 2'b00} +: 4];
        baud_last = (baud_q == BaudLast);
        case (eff_idx)
            4'd8:    char_byte = 8'h20;
            4'd9:    char_byte = hex_char(flag_q[7:4]);
            4'd10:   char_byte = hex_char(flag_q[3:0]);
            4'd11:   char_byte = 8'h0D;
            4'd12:   char_byte = 8'h0A;
            default: char_byte = hex_char(nib);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            chr_q    <= '0;
            result_q <= '0;
            flag_q   <= '0;
            mode_q   <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (send_i) begin
                        result_q <= result_i;
                        flag_q   <= {3'b000, flags_i};
                        mode_q   <= mode_fp_i;
                        state_q  <= StStart;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        baud_q   <= '0;
                        bit_q    <= '0;
                        chr_q    <= '0;
                    end
                end
                StStart: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= char_byte[0];
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= char_byte[bit_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StStop: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (chr_q == last_idx) begin
                            chr_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap.
                            chr_q   <= chr_q + 4'd1;
                            tx_q    <= 1'b0;
                            state_q <= StStart;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
